s_term_edge_ingress: RTL

- Registered, elastic ingress stage directly upstream of the south terminal tile's switch matrix.
- Accepts 12-bit words from the south fabric edge (I/O or macro side) over a valid/ready handshake and buffers them in a small FIFO.
- Presents each word on the S-term input wires (SA0..SI2) for a guaranteed settle time before asserting valid. The terminal switch matrix then passes the wires straight north into the fabric.
- Fabric logic acknowledges consumption with a take pulse, which advances to the next word.

---
 rtl/s_term_edge_pkg.sv | 27 ++
 rtl/s_term_edge_fifo.sv | 59 +++++
 rtl/s_term_edge_ingress.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/s_term_edge_pkg.sv
// Shared definitions for the south-terminal edge ingress stage: default word
// width, bit positions of the S-term wires inside a word, and FSM states.
package s_term_edge_pkg;

  localparam int S_TERM_WIDTH = 12;

  // Bit positions of each S-term wire inside a word (bit 0 = SA0).
  localparam int SA0_IDX = 0;
  localparam int SB0_IDX = 1;
  localparam int SC0_IDX = 2;
  localparam int SD0_IDX = 3;
  localparam int SF0_IDX = 4;
  localparam int SG0_IDX = 5;
  localparam int SG1_IDX = 6;
  localparam int SH0_IDX = 7;
  localparam int SH1_IDX = 8;
  localparam int SI0_IDX = 9;
  localparam int SI1_IDX = 10;
  localparam int SI2_IDX = 11;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    SETTLE  = 2'd1,
    PRESENT = 2'd2
  } state_e;

endpackage

// File: rtl/s_term_edge_fifo.sv
// DEPTH-entry synchronous FIFO. The caller guarantees push only when not full
// and pop only when not empty; head_o shows the oldest entry combinationally.
module s_term_edge_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [W-1:0]           push_data_i,
  input  logic                   pop_i,
  output logic [W-1:0]           head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Next pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the FIFO.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are meaningless while count is zero, so no reset.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/s_term_edge_ingress.sv
// Elastic ingress stage feeding the south terminal tile's S-term wires.
// Words from the fabric edge are buffered in a FIFO, loaded into a registered
// output, held for HOLD_CYCLES to settle, then flagged valid until the fabric
// takes them. Optional build macro S_TERM_EDGE_PARITY_EN adds ext_parity /
// parity_err (even parity carried through the FIFO, checked on load).
//
// Handshake: a word is pushed at a rising UserCLK edge where ext_valid and
// ext_ready are both high; ext_ready depends only on the registered count, so
// a full FIFO refuses data even in a cycle where a pop happens. On the output
// side fabric_take consumes the presented word only while from_S_valid is high.
module s_term_edge_ingress
  import s_term_edge_pkg::*;
#(
  parameter int WIDTH       = S_TERM_WIDTH,
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                   UserCLK,
  input  logic                   resetn,
  input  logic [WIDTH-1:0]       ext_data,
  input  logic                   ext_valid,
  output logic                   ext_ready,
`ifdef S_TERM_EDGE_PARITY_EN
  input  logic                   ext_parity,
  output logic                   parity_err,
`endif
  input  logic                   fabric_take,
  output logic [WIDTH-1:0]       from_S_bus,
  output logic                   from_S_valid,
  output logic [$clog2(DEPTH):0] fill_level,
  output logic                   take_early,
  output logic [1:0]             dbg_state
);

  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HCW-1:0] HOLD_RELOAD = HCW'(HOLD_CYCLES - 1);

`ifdef S_TERM_EDGE_PARITY_EN
  localparam int FW = WIDTH + 1;
`else
  localparam int FW = WIDTH;
`endif

  logic [FW-1:0]    fifo_in, fifo_head;
  logic [CW-1:0]    count;
  logic             push, pop;
  state_e           state_q, state_d;
  logic [HCW-1:0]   hold_q, hold_d;
  logic [WIDTH-1:0] bus_q, bus_d;
  logic             early_q, early_d;

`ifdef S_TERM_EDGE_PARITY_EN
  logic par_err_q, par_err_d;
  assign fifo_in = {ext_parity, ext_data};
`else
  assign fifo_in = ext_data;
`endif

  assign ext_ready = (count < CW'(DEPTH));
  assign push      = ext_valid & ext_ready;

  s_term_edge_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (UserCLK),
    .rst_ni      (resetn),
    .push_i      (push),
    .push_data_i (fifo_in),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .count_o     (count)
  );

  // Presentation FSM: load a word, let it settle, then hold it valid until taken.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    bus_d   = bus_q;
    pop     = 1'b0;
    early_d = early_q | (fabric_take & (state_q != PRESENT));
    case (state_q)
      EMPTY: begin
        if (count != '0) pop = 1'b1;
      end
      SETTLE: begin
        if (hold_q == '0) state_d = PRESENT;
        else              hold_d  = hold_q - HCW'(1);
      end
      PRESENT: begin
        if (fabric_take) begin
          if (count != '0) pop     = 1'b1;
          else             state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (pop) begin
      bus_d   = fifo_head[WIDTH-1:0];
      hold_d  = HOLD_RELOAD;
      state_d = SETTLE;
    end
  end

`ifdef S_TERM_EDGE_PARITY_EN
  // Even parity: the stored bit plus data must XOR to zero when loaded.
  always_comb begin
    par_err_d = par_err_q | (pop & (^fifo_head));
  end

  // Sticky parity error flag.
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) par_err_q <= 1'b0;
    else         par_err_q <= par_err_d;
  end

  assign parity_err = par_err_q;
`endif

  // State, hold counter, output word and sticky early-take flag.
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      state_q <= EMPTY;
      hold_q  <= '0;
      bus_q   <= '0;
      early_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      bus_q   <= bus_d;
      early_q <= early_d;
    end
  end

  assign from_S_bus   = bus_q;
  assign from_S_valid = (state_q == PRESENT);
  assign fill_level   = count;
  assign take_early   = early_q;
  assign dbg_state    = state_q;

endmodule
